// File: rtl/quad_encoder_bank_if.sv
// rtl/quad_encoder_bank_if.sv - encoder bank signal bundle; error vector present only with ENC_ERROR_EN
interface quad_encoder_bank_if #(
    parameter int NUM_CH   = 3,
    parameter int DATA_LEN = 8
);
    logic [NUM_CH-1:0]          a;
    logic [NUM_CH-1:0]          b;
    logic [NUM_CH-1:0]          clear;
    logic [NUM_CH*DATA_LEN-1:0] value;
    logic [NUM_CH-1:0]          changed;
    logic [NUM_CH-1:0]          dir;
`ifdef ENC_ERROR_EN
    logic [NUM_CH-1:0]          error;

    modport master (output a, b, clear, input value, changed, dir, error);
    modport slave  (input a, b, clear, output value, changed, dir, error);
`else
    modport master (output a, b, clear, input value, changed, dir);
    modport slave  (input a, b, clear, output value, changed, dir);
`endif
endinterface

// File: rtl/quad_encoder_bank.sv
// rtl/quad_encoder_bank.sv - multi-channel quadrature encoder front end (sync, debounce, decode, count)
// Optional sticky illegal-transition flag enabled by defining ENC_ERROR_EN.
module quad_encoder_bank #(
    parameter int NUM_CH      = 3,
    parameter int DATA_LEN    = 8,
    parameter int INC_STEP    = 1,
    parameter int DEBOUNCE    = 4,
    parameter int MODE        = 4,
    parameter int SATURATE    = 0,
    parameter int RESET_VALUE = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    quad_encoder_bank_if.slave   bus
);

    localparam int                CW      = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE);
    localparam logic [DATA_LEN:0] STEP    = (DATA_LEN+1)'(INC_STEP);
    localparam logic [DATA_LEN-1:0] RST_VAL = DATA_LEN'(RESET_VALUE);
    localparam logic [DATA_LEN-1:0] MAX_VAL = '1;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // Bit 1 is A, bit 0 is B throughout.
        logic [1:0]          sync1, sync2, filt, prev;
        logic                a_chg, b_chg, cnt_en, up, illegal;
        logic [DATA_LEN:0]   sum, diff;
        logic [DATA_LEN-1:0] next_val, val_q;
        logic                chg_q, dir_q;

        always_ff @(posedge clk) begin
            sync1 <= {bus.a[i], bus.b[i]};
            sync2 <= sync1;
        end

        if (DEBOUNCE == 0) begin : g_nodb
            assign filt = sync2;
        end else begin : g_db
            logic [CW-1:0] db_cnt [2];

            always_ff @(posedge clk) begin
                for (int k = 0; k < 2; k++) begin
                    if (reset) begin
                        filt[k]   <= sync2[k];
                        db_cnt[k] <= '0;
                    end else if (sync2[k] != filt[k]) begin
                        if (db_cnt[k] == CW'(DEBOUNCE - 1)) begin
                            filt[k]   <= sync2[k];
                            db_cnt[k] <= '0;
                        end else begin
                            db_cnt[k] <= db_cnt[k] + 1'b1;
                        end
                    end else begin
                        db_cnt[k] <= '0;
                    end
                end
            end
        end

        always_comb begin
            a_chg   = prev[1] ^ filt[1];
            b_chg   = prev[0] ^ filt[0];
            illegal = a_chg & b_chg;
            // A edge: up when A and B now differ; B edge: up when they now match.
            up      = a_chg ? (filt[1] ^ filt[0]) : ~(filt[1] ^ filt[0]);
            if (MODE == 1)
                cnt_en = a_chg & ~b_chg & filt[1];
            else if (MODE == 2)
                cnt_en = a_chg & ~b_chg;
            else
                cnt_en = a_chg ^ b_chg;

            sum  = {1'b0, val_q} + STEP;
            diff = {1'b0, val_q} - STEP;
            if (up)
                next_val = (SATURATE != 0 && sum[DATA_LEN])  ? MAX_VAL : sum[DATA_LEN-1:0];
            else
                next_val = (SATURATE != 0 && diff[DATA_LEN]) ? '0      : diff[DATA_LEN-1:0];
        end

        always_ff @(posedge clk) begin
            prev <= reset ? sync2 : filt;
        end

`ifdef ENC_ERROR_EN
        logic err_q;
        assign bus.error[i] = err_q;
`endif

        always_ff @(posedge clk) begin
            if (reset) begin
                val_q <= RST_VAL;
                chg_q <= 1'b0;
                dir_q <= 1'b0;
`ifdef ENC_ERROR_EN
                err_q <= 1'b0;
`endif
            end else if (bus.clear[i]) begin
                val_q <= RST_VAL;
                chg_q <= 1'b0;
`ifdef ENC_ERROR_EN
                err_q <= 1'b0;
`endif
            end else begin
                chg_q <= cnt_en;
                if (cnt_en) begin
                    val_q <= next_val;
                    dir_q <= up;
                end
`ifdef ENC_ERROR_EN
                if (illegal)
                    err_q <= 1'b1;
`endif
            end
        end

        assign bus.value[i*DATA_LEN +: DATA_LEN] = val_q;
        assign bus.changed[i]                    = chg_q;
        assign bus.dir[i]                        = dir_q;
    end

endmodule

// File: tb/tb_quad_encoder_bank.sv
// tb/tb_quad_encoder_bank.sv - directed self-checking bench for quad_encoder_bank over several parameter sets
module tb_quad_encoder_bank;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    quad_encoder_bank_if #(.NUM_CH(3), .DATA_LEN(8)) if0 ();
    quad_encoder_bank_if #(.NUM_CH(3), .DATA_LEN(8)) if1 ();
    quad_encoder_bank_if #(.NUM_CH(3), .DATA_LEN(8)) if2 ();
    quad_encoder_bank_if #(.NUM_CH(3), .DATA_LEN(8)) if3 ();
    quad_encoder_bank_if #(.NUM_CH(3), .DATA_LEN(8)) if4 ();
    quad_encoder_bank_if #(.NUM_CH(3), .DATA_LEN(8)) if5 ();

    quad_encoder_bank #(.DEBOUNCE(4), .MODE(4), .SATURATE(0)) u0 (.clk(clk), .reset(reset), .bus(if0.slave));
    quad_encoder_bank #(.DEBOUNCE(0), .MODE(4), .SATURATE(1), .RESET_VALUE(254)) u1 (.clk(clk), .reset(reset), .bus(if1.slave));
    quad_encoder_bank #(.DEBOUNCE(0), .MODE(4), .SATURATE(0), .RESET_VALUE(254)) u2 (.clk(clk), .reset(reset), .bus(if2.slave));
    quad_encoder_bank #(.DEBOUNCE(0), .MODE(1), .RESET_VALUE(10)) u3 (.clk(clk), .reset(reset), .bus(if3.slave));
    quad_encoder_bank #(.DEBOUNCE(0), .MODE(2), .RESET_VALUE(10)) u4 (.clk(clk), .reset(reset), .bus(if4.slave));
    quad_encoder_bank #(.DEBOUNCE(0), .MODE(4)) u5 (.clk(clk), .reset(reset), .bus(if5.slave));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // u0 ch0 (DEBOUNCE=4): update must land exactly on the 7th edge after the input change.
    task automatic u0_step(input logic [1:0] ab, input int exp_old, input int exp_new);
        if0.a[0] = ab[1];
        if0.b[0] = ab[0];
        tick(6);
        check_eq("u0 value before latency", 32'(if0.value[7:0]), 32'(exp_old));
        check_eq("u0 changed before latency", 32'(if0.changed[0]), 32'd0);
        tick(1);
        check_eq("u0 value at latency", 32'(if0.value[7:0]), 32'(exp_new));
        check_eq("u0 changed at latency", 32'(if0.changed[0]), 32'd1);
        tick(1);
        check_eq("u0 changed one cycle", 32'(if0.changed[0]), 32'd0);
        tick(2);
    endtask

    // u1 (saturate) and u2 (wrap) ch0 driven identically, DEBOUNCE=0 -> 3-edge latency.
    task automatic sat_step(input logic [1:0] ab, input int exp_sat, input int exp_wrap);
        if1.a[0] = ab[1]; if1.b[0] = ab[0];
        if2.a[0] = ab[1]; if2.b[0] = ab[0];
        tick(2);
        check_eq("u1 changed early", 32'(if1.changed[0]), 32'd0);
        tick(1);
        check_eq("u1 sat value", 32'(if1.value[7:0]), 32'(exp_sat));
        check_eq("u1 sat changed", 32'(if1.changed[0]), 32'd1);
        check_eq("u2 wrap value", 32'(if2.value[7:0]), 32'(exp_wrap));
        check_eq("u2 wrap changed", 32'(if2.changed[0]), 32'd1);
        tick(2);
    endtask

    initial begin
        int p3, p4, p0;
        logic [1:0] rev [4];
        rev[0] = 2'b10; rev[1] = 2'b00; rev[2] = 2'b01; rev[3] = 2'b11;

        if0.a = 3'b111; if0.b = 3'b111; if0.clear = '0;
        if1.a = 3'b111; if1.b = 3'b111; if1.clear = '0;
        if2.a = 3'b111; if2.b = 3'b111; if2.clear = '0;
        if3.a = 3'b111; if3.b = 3'b111; if3.clear = '0;
        if4.a = 3'b111; if4.b = 3'b111; if4.clear = '0;
        if5.a = 3'b111; if5.b = 3'b111; if5.clear = '0;

        // 1: reset with AB idle 11
        reset = 1'b1;
        tick(4);
        reset = 1'b0;
        check_eq("reset value", 32'(if0.value), 32'd0);
        check_eq("reset changed", 32'(if0.changed), 32'd0);
        check_eq("reset dir", 32'(if0.dir), 32'd0);
        check_eq("reset value rv", 32'(if1.value[7:0]), 32'd254);
        tick(10);
        check_eq("post-release value", 32'(if0.value), 32'd0);
        check_eq("post-release u5 value", 32'(if5.value), 32'd0);
        check_eq("post-release changed", 32'(if0.changed | if5.changed), 32'd0);

        // 2: bring ch0 to 00 going backwards (wraps below zero), clear, then one forward cycle
        u0_step(2'b10, 0, 255);
        check_eq("u0 dir down", 32'(if0.dir[0]), 32'd0);
        u0_step(2'b00, 255, 254);
        if0.clear[0] = 1'b1;
        tick(1);
        if0.clear[0] = 1'b0;
        check_eq("u0 clear", 32'(if0.value[7:0]), 32'd0);
        u0_step(2'b10, 0, 1);
        u0_step(2'b11, 1, 2);
        u0_step(2'b01, 2, 3);
        u0_step(2'b00, 3, 4);
        check_eq("u0 forward value", 32'(if0.value[7:0]), 32'd4);
        check_eq("u0 dir up", 32'(if0.dir[0]), 32'd1);
        check_eq("u0 other channels", 32'(if0.value[23:8]), 32'd0);

        // 3: 3-cycle glitch on A is filtered out
        if0.a[0] = 1'b1;
        tick(3);
        if0.a[0] = 1'b0;
        p0 = 0;
        for (int k = 0; k < 15; k++) begin
            tick(1);
            p0 += int'(if0.changed[0]);
        end
        check_eq("glitch pulses", 32'(p0), 32'd0);
        check_eq("glitch value", 32'(if0.value[7:0]), 32'd4);

        // 4: three up counts from 254, saturate vs wrap
        sat_step(2'b01, 255, 255);
        sat_step(2'b00, 255, 0);
        sat_step(2'b10, 255, 1);

        // 5: one full reverse cycle in MODE 1 and MODE 2
        p3 = 0; p4 = 0;
        for (int s = 0; s < 4; s++) begin
            if3.a[0] = rev[s][1]; if3.b[0] = rev[s][0];
            if4.a[0] = rev[s][1]; if4.b[0] = rev[s][0];
            for (int k = 0; k < 5; k++) begin
                tick(1);
                p3 += int'(if3.changed[0]);
                p4 += int'(if4.changed[0]);
            end
        end
        check_eq("mode1 value", 32'(if3.value[7:0]), 32'd9);
        check_eq("mode1 pulses", 32'(p3), 32'd1);
        check_eq("mode2 value", 32'(if4.value[7:0]), 32'd8);
        check_eq("mode2 pulses", 32'(p4), 32'd2);
        check_eq("mode2 dir", 32'(if4.dir[0]), 32'd0);

        // 6: illegal transition, then clear[0] coinciding with a ch1 count
        if5.a[0] = 1'b0;
        tick(4);
        check_eq("u5 pre value", 32'(if5.value[7:0]), 32'd1);
        check_eq("u5 pre dir", 32'(if5.dir[0]), 32'd1);
        if5.a[0] = 1'b1; if5.b[0] = 1'b0;
        p0 = 0;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            p0 += int'(if5.changed[0]);
        end
        check_eq("illegal pulses", 32'(p0), 32'd0);
        check_eq("illegal value", 32'(if5.value[7:0]), 32'd1);
        check_eq("illegal dir", 32'(if5.dir[0]), 32'd1);
`ifdef ENC_ERROR_EN
        check_eq("error set", 32'(if5.error[0]), 32'd1);
`endif
        if5.a[1] = 1'b0;
        tick(2);
        if5.clear[0] = 1'b1;
        tick(1);
        if5.clear[0] = 1'b0;
        check_eq("clear value0", 32'(if5.value[7:0]), 32'd0);
        check_eq("clear changed0", 32'(if5.changed[0]), 32'd0);
        check_eq("ch1 value", 32'(if5.value[15:8]), 32'd1);
        check_eq("ch1 changed", 32'(if5.changed[1]), 32'd1);
        check_eq("ch1 dir", 32'(if5.dir[1]), 32'd1);
`ifdef ENC_ERROR_EN
        check_eq("error cleared", 32'(if5.error[0]), 32'd0);
        check_eq("error ch1", 32'(if5.error[1]), 32'd0);
`endif
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
